periph_port_responder: RTL and testbench

PERIPH_PORT_RESPONDER -- requirements
Module: periph_port_responder

---
 rtl/periph_port_pkg.sv | 40 ++++
 rtl/periph_port_responder_if.sv | 31 +++
 rtl/periph_event_fifo.sv | 54 +++++
 rtl/periph_port_responder.sv | 149 ++++++++++++++
 tb/tb_periph_port_responder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_port_pkg.sv
// Shared register map, CTRL/STATUS bit positions and interrupt FSM encoding for the
// processor-port responder.
package periph_port_pkg;

    localparam int unsigned DataW = 8;

    localparam logic [7:0] OffCtrl   = 8'd0;
    localparam logic [7:0] OffStatus = 8'd1;
    localparam logic [7:0] OffEvdata = 8'd2;
    localparam logic [7:0] OffTxdata = 8'd3;
    localparam logic [7:0] OffOvfclr = 8'd4;
    localparam logic [7:0] NumRegs   = 8'd5;

    localparam int unsigned CtrlIrqEnBit = 0;
    localparam int unsigned CtrlFlushBit = 1;

    localparam int unsigned StatusEmptyBit = 0;
    localparam int unsigned StatusFullBit  = 1;
    localparam int unsigned StatusOvfBit   = 2;
    localparam int unsigned StatusCntLsb   = 4;
    localparam int unsigned StatusCntMsb   = 6;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StService = 2'd2
    } irq_state_e;

    function automatic logic [7:0] pack_status(logic empty, logic full, logic ovf,
                                               logic [2:0] cnt);
        logic [7:0] s;
        s = '0;
        s[StatusEmptyBit] = empty;
        s[StatusFullBit]  = full;
        s[StatusOvfBit]   = ovf;
        s[StatusCntMsb:StatusCntLsb] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/periph_port_responder_if.sv
// Processor port bus plus event-source and transmit-side signals of the responder.
interface periph_port_responder_if;
    import periph_port_pkg::*;

    logic [DataW-1:0] port_id;
    logic [DataW-1:0] out_port;
    logic             write_strobe;
    logic             k_write_strobe;
    logic             read_strobe;
    logic [DataW-1:0] in_port;
    logic             interrupt;
    logic             interrupt_ack;
    logic [DataW-1:0] ev_data;
    logic             ev_valid;
    logic             ev_ready;
    logic [DataW-1:0] tx_data;
    logic             tx_stb;

    modport master (
        output port_id, out_port, write_strobe, k_write_strobe, read_strobe,
        output interrupt_ack, ev_data, ev_valid,
        input  in_port, interrupt, ev_ready, tx_data, tx_stb
    );

    modport slave (
        input  port_id, out_port, write_strobe, k_write_strobe, read_strobe,
        input  interrupt_ack, ev_data, ev_valid,
        output in_port, interrupt, ev_ready, tx_data, tx_stb
    );

endinterface

// File: rtl/periph_event_fifo.sv
// Power-of-two event FIFO with flush; flush overrides any same-cycle push or pop.
module periph_event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && !flush && !empty;
        // A push into a full FIFO is allowed only when the same cycle frees a slot.
        do_push = push && !flush && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    always_comb begin
        head  = mem[rd_ptr_q];
        count = count_q;
        full  = (count_q == CntW'(DEPTH));
        empty = (count_q == '0);
    end

endmodule

// File: rtl/periph_port_responder.sv
// Five-register processor-port peripheral: event FIFO, transmit byte, level interrupt.
module periph_port_responder
    import periph_port_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h00,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                     clk,
    input logic                     reset,
    periph_port_responder_if.slave  bus
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]      rd_off, wr_off;
    logic [3:0]      k_off;
    logic            wr_en;
    logic            ctrl_wr, tx_wr, ovfclr_wr, flush;
    logic            push, pop, ovf_set;
    logic [7:0]      fifo_head;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty;
    logic [3:0]      cnt_wide;
    logic [2:0]      cnt_sat;
    logic [7:0]      status, rd_data;

    logic            irq_en_q, ovf_q, tx_stb_q;
    logic [7:0]      in_port_q, tx_data_q;
    irq_state_e      state_q, state_d;
    logic            irq;

    // Write decode: full port_id for write_strobe, low nibble only for k_write_strobe.
    always_comb begin
        rd_off = bus.port_id - BASE_ADDR;
        k_off  = bus.port_id[3:0] - BASE_ADDR[3:0];
        wr_off = '0;
        wr_en  = 1'b0;
        if (bus.write_strobe) begin
            wr_off = rd_off;
            wr_en  = (rd_off < NumRegs);
        end else if (bus.k_write_strobe) begin
            wr_off = {4'h0, k_off};
            wr_en  = (wr_off < NumRegs);
        end
    end

    always_comb begin
        ctrl_wr   = wr_en && (wr_off == OffCtrl);
        tx_wr     = wr_en && (wr_off == OffTxdata);
        ovfclr_wr = wr_en && (wr_off == OffOvfclr);
        flush     = ctrl_wr && bus.out_port[CtrlFlushBit];
        pop       = bus.read_strobe && (rd_off == OffEvdata) && !fifo_empty;
        push      = bus.ev_valid && (!fifo_full || pop);
        // Flush leaves overflow untouched, so a dropped byte during flush is not flagged.
        ovf_set   = bus.ev_valid && fifo_full && !pop && !flush;
    end

    periph_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DataW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (bus.ev_data),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        cnt_wide = 4'(fifo_count);
        cnt_sat  = (cnt_wide > 4'd7) ? 3'd7 : cnt_wide[2:0];
        status   = pack_status(fifo_empty, fifo_full, ovf_q, cnt_sat);
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            OffCtrl:   rd_data[CtrlIrqEnBit] = irq_en_q;
            OffStatus: rd_data = status;
            OffEvdata: rd_data = fifo_empty ? 8'h00 : fifo_head;
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            in_port_q <= '0;
            tx_data_q <= '0;
            tx_stb_q  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= bus.out_port[CtrlIrqEnBit];
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovfclr_wr) begin
                ovf_q <= 1'b0;
            end
            in_port_q <= rd_data;
            tx_stb_q  <= tx_wr;
            if (tx_wr) tx_data_q <= bus.out_port;
        end
    end

    // Interrupt FSM: state register, next-state logic, output decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (irq_en_q && !fifo_empty) state_d = StAssert;
            end
            StAssert: begin
                if (!irq_en_q) begin
                    state_d = StIdle;
                end else if (bus.interrupt_ack) begin
                    state_d = StService;
                end
            end
            StService: begin
                if (fifo_empty) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        irq = (state_q == StAssert);
    end

    assign bus.in_port   = in_port_q;
    assign bus.interrupt = irq;
    assign bus.ev_ready  = !fifo_full;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_stb    = tx_stb_q;

endmodule

// File: tb/tb_periph_port_responder.sv
// Directed bench: stimulus pushes expected read/transmit bytes into queues, a negedge
// monitor pops and compares whenever read_strobe or tx_stb is presented.
module tb_periph_port_responder;

    logic clk;
    logic reset;

    periph_port_responder_if bus ();

    periph_port_responder #(
        .BASE_ADDR  (8'h00),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
    } exp_t;

    exp_t rd_q[$];
    exp_t tx_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expected entry.
    always @(negedge clk) begin
        if (bus.read_strobe) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h, want no read", bus.in_port);
            end else begin
                exp_t e;
                e = rd_q.pop_front();
                check(e.name, bus.in_port, e.data);
            end
        end
        if (bus.tx_stb) begin
            if (tx_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL tx_unexpected: got tx_stb with %0h, want no strobe", bus.tx_data);
            end else begin
                exp_t e;
                e = tx_q.pop_front();
                check(e.name, bus.tx_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        bus.port_id      = port;
        bus.out_port     = data;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
    endtask

    task automatic kwr(input logic [7:0] port, input logic [7:0] data);
        bus.port_id        = port;
        bus.out_port       = data;
        bus.k_write_strobe = 1'b1;
        tick();
        bus.k_write_strobe = 1'b0;
    endtask

    // port_id is set up one cycle ahead of read_strobe, as the processor does.
    task automatic rd(input string name, input logic [7:0] port, input logic [7:0] exp);
        exp_t e;
        bus.port_id = port;
        tick();
        e.name = name;
        e.data = exp;
        rd_q.push_back(e);
        bus.read_strobe = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
    endtask

    task automatic push_ev(input logic [7:0] d);
        bus.ev_data  = d;
        bus.ev_valid = 1'b1;
        tick();
        bus.ev_valid = 1'b0;
    endtask

    task automatic expect_tx(input string name, input logic [7:0] d);
        exp_t e;
        e.name = name;
        e.data = d;
        tx_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        bus.port_id        = 8'h00;
        bus.out_port       = 8'h00;
        bus.write_strobe   = 1'b0;
        bus.k_write_strobe = 1'b0;
        bus.read_strobe    = 1'b0;
        bus.interrupt_ack  = 1'b0;
        bus.ev_data        = 8'h00;
        bus.ev_valid       = 1'b0;
        reset              = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_in_port", bus.in_port, 8'h00);
        check("rst_ev_ready", bus.ev_ready, 1);
        check("rst_interrupt", bus.interrupt, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_tx_stb", bus.tx_stb, 0);
        reset = 1'b0;
        tick();
        rd("rst_status", 8'h01, 8'h01);
        rd("rst_ctrl", 8'h00, 8'h00);
        rd("unmapped_05", 8'h05, 8'h00);
        rd("unmapped_10", 8'h10, 8'h00);

        // Two events then in-order readout
        push_ev(8'hA5);
        push_ev(8'h3C);
        rd("status_two", 8'h01, 8'h20);
        rd("evdata_a5", 8'h02, 8'hA5);
        rd("evdata_3c", 8'h02, 8'h3C);
        rd("status_drained", 8'h01, 8'h01);
        rd("evdata_empty", 8'h02, 8'h00);
        rd("status_after_empty_rd", 8'h01, 8'h01);

        // Transmit: k-write decodes low nibble only, normal write decodes full port_id
        expect_tx("tx_kwrite", 8'h7E);
        kwr(8'hF3, 8'h7E);
        check("tx_stb_high", bus.tx_stb, 1);
        tick();
        check("tx_stb_one_cycle", bus.tx_stb, 0);
        expect_tx("tx_write", 8'h5A);
        wr(8'h03, 8'h5A);
        check("tx_stb_high2", bus.tx_stb, 1);
        wr(8'hF3, 8'h99);
        check("tx_full_decode_ignored_stb", bus.tx_stb, 0);
        check("tx_full_decode_ignored_data", bus.tx_data, 8'h5A);

        // Overflow: fifth byte dropped, sticky flag, OVFCLR
        push_ev(8'h10);
        push_ev(8'h11);
        push_ev(8'h12);
        push_ev(8'h13);
        check("ev_ready_full", bus.ev_ready, 0);
        push_ev(8'h14);
        rd("status_ovf", 8'h01, 8'h46);
        wr(8'h04, 8'hFF);
        rd("status_ovfclr", 8'h01, 8'h42);
        rd("evdata_10", 8'h02, 8'h10);
        check("ev_ready_after_pop", bus.ev_ready, 1);
        rd("evdata_11", 8'h02, 8'h11);
        rd("evdata_12", 8'h02, 8'h12);
        rd("evdata_13", 8'h02, 8'h13);
        rd("status_dropped", 8'h01, 8'h01);

        // Full FIFO with simultaneous push and pop
        push_ev(8'h21);
        push_ev(8'h22);
        push_ev(8'h23);
        push_ev(8'h24);
        bus.port_id = 8'h02;
        tick();
        e.name = "evdata_simul_21";
        e.data = 8'h21;
        rd_q.push_back(e);
        bus.read_strobe = 1'b1;
        bus.ev_data     = 8'h25;
        bus.ev_valid    = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
        bus.ev_valid    = 1'b0;
        rd("status_simul", 8'h01, 8'h42);
        rd("evdata_22", 8'h02, 8'h22);
        rd("evdata_23", 8'h02, 8'h23);
        wr(8'h00, 8'h02);
        rd("status_flushed", 8'h01, 8'h01);

        // Interrupt FSM
        wr(8'h00, 8'h03);
        rd("ctrl_flush_reads0", 8'h00, 8'h01);
        check("irq_idle_empty", bus.interrupt, 0);
        push_ev(8'h11);
        tick();
        check("irq_assert", bus.interrupt, 1);
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        check("irq_ack_low", bus.interrupt, 0);
        tick();
        check("irq_service_low", bus.interrupt, 0);
        rd("evdata_irq_11", 8'h02, 8'h11);
        tick();
        check("irq_idle_after_drain", bus.interrupt, 0);
        push_ev(8'h33);
        tick();
        check("irq_reassert", bus.interrupt, 1);
        wr(8'h00, 8'h00);
        tick();
        check("irq_disabled", bus.interrupt, 0);
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        wr(8'h00, 8'h01);
        tick();
        check("irq_ack_ignored_idle", bus.interrupt, 1);
        rd("evdata_irq_33", 8'h02, 8'h33);
        wr(8'h00, 8'h00);

        // Reset mid-transaction discards FIFO and the same-cycle TXDATA write
        push_ev(8'h55);
        push_ev(8'h66);
        bus.port_id      = 8'h03;
        bus.out_port     = 8'hAA;
        bus.write_strobe = 1'b1;
        reset            = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
        reset            = 1'b0;
        check("midrst_tx_stb", bus.tx_stb, 0);
        check("midrst_tx_data", bus.tx_data, 8'h00);
        check("midrst_ev_ready", bus.ev_ready, 1);
        rd("midrst_status", 8'h01, 8'h01);
        rd("midrst_evdata", 8'h02, 8'h00);

        repeat (2) tick();
        check("rd_queue_drained", rd_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
